// File: rtl/mem_stage_dmem.sv
// mem_stage_dmem: MEM-stage data memory with multi-cycle access.
// Consumes the EX/MEM register outputs, freezes the upstream pipeline while
// an access is in flight and hands load data to the MEM/WB register.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-low reset
//   MemRead_i    load request
//   MemWrite_i   store request (wins over MemRead_i)
//   ALUResult_i  byte address; word index is ALUResult_i[ADDR_W+1:2]
//   MUX2Result_i store data
//   stall_o      combinational freeze for PC/IF_ID/ID_EX/EX_MEM
//   valid_o      one-cycle pulse in the cycle an access completes
//   MemData_o    load data, held until the next load completes
//   err_o        (only with DMEM_MISALIGN_TRAP_EN) pulse the cycle after a
//                rejected misaligned request
//
// Optional feature macro: DMEM_MISALIGN_TRAP_EN
module mem_stage_dmem #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 4,
  parameter int unsigned ADDR_W  = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] MUX2Result_i,
  output logic        stall_o,
  output logic        valid_o,
`ifdef DMEM_MISALIGN_TRAP_EN
  output logic        err_o,
`endif
  output logic [31:0] MemData_o
);

  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state, nextState;
  logic [CNT_W-1:0]  count, nextCount;

  logic              opWrite;
  logic [ADDR_W-1:0] latchIdx;
  logic [31:0]       latchData;

  logic [31:0]       mem [DEPTH];

  logic              req;
  logic              accept;
  logic              commit;
  logic              commitWrite;
  logic [ADDR_W-1:0] commitIdx;
  logic [31:0]       commitData;
  logic [ADDR_W-1:0] liveIdx;

  // Address bits outside the word index only matter to the misalign trap.
  logic unusedAddrBits;
  assign unusedAddrBits = ^{ALUResult_i[31:ADDR_W+2], ALUResult_i[1:0]};

  assign req     = MemRead_i | MemWrite_i;
  assign liveIdx = ALUResult_i[ADDR_W+1:2];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign accept = req & (ALUResult_i[1:0] == 2'b00);
`else
  assign accept = req;
`endif

  // Next-state and counter logic.
  always_comb begin
    nextState = state;
    nextCount = count;
    case (state)
      IDLE: begin
        if (accept) begin
          nextState = (LATENCY > 1) ? WAIT : DONE;
          nextCount = CNT_W'(LATENCY - 1);
        end
      end
      WAIT: begin
        nextCount = count - CNT_W'(1);
        if (count == CNT_W'(1)) begin
          nextState = DONE;
        end
      end
      DONE: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
        nextCount = '0;
      end
    endcase
  end

  // Commit on the edge entering DONE; single-cycle latency commits straight
  // from IDLE using the live request since nothing has been latched yet.
  always_comb begin
    commit      = ((state == IDLE) && accept && (LATENCY == 1)) ||
                  ((state == WAIT) && (count == CNT_W'(1)));
    commitWrite = (state == IDLE) ? MemWrite_i   : opWrite;
    commitIdx   = (state == IDLE) ? liveIdx      : latchIdx;
    commitData  = (state == IDLE) ? MUX2Result_i : latchData;
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= nextState;
      count <= nextCount;
    end
  end

  // Request capture; WAIT works only from these copies.
  always_ff @(posedge clk_i) begin
    if ((state == IDLE) && accept) begin
      opWrite   <= MemWrite_i;
      latchIdx  <= liveIdx;
      latchData <= MUX2Result_i;
    end
  end

  // Data array: never cleared, a reset edge aborts a pending write.
  always_ff @(posedge clk_i) begin
    if (rst_i && commit && commitWrite) begin
      mem[commitIdx] <= commitData;
    end
  end

  // Load data register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      MemData_o <= '0;
    end else if (commit && !commitWrite) begin
      MemData_o <= mem[commitIdx];
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  // Misalign trap pulse, one cycle after the rejected request.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      err_o <= 1'b0;
    end else begin
      err_o <= (state == IDLE) && req && !accept;
    end
  end
`endif

  assign stall_o = rst_i & (((state == IDLE) & accept) | (state == WAIT));
  assign valid_o = (state == DONE);

endmodule

// File: tb/tb_mem_stage_dmem.sv
module tb_mem_stage_dmem;

  localparam int unsigned DEPTH   = 64;
  localparam int unsigned LATENCY = 4;

  logic        clk_i;
  logic        rst_i;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [31:0] ALUResult_i;
  logic [31:0] MUX2Result_i;
  logic        stall_o;
  logic        valid_o;
  logic [31:0] MemData_o;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic        err_o;
`endif

  mem_stage_dmem #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .MemRead_i   (MemRead_i),
    .MemWrite_i  (MemWrite_i),
    .ALUResult_i (ALUResult_i),
    .MUX2Result_i(MUX2Result_i),
    .stall_o     (stall_o),
    .valid_o     (valid_o),
`ifdef DMEM_MISALIGN_TRAP_EN
    .err_o       (err_o),
`endif
    .MemData_o   (MemData_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Reference: word array indexed modulo DEPTH, plus the last load value.
  logic [31:0] model [DEPTH];
  logic [31:0] expData;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One instruction held until its DONE cycle; returns just after the
  // edge that ends DONE so the next call is back-to-back.
  task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data);
    int  stalls = 0;
    bit  seen   = 0;
    int  idx    = int'((addr >> 2) % DEPTH);
    MemRead_i    = rd;
    MemWrite_i   = wr;
    ALUResult_i  = addr;
    MUX2Result_i = data;
    if (wr)      model[idx] = data;
    else if (rd) expData    = model[idx];
    for (int c = 0; c < int'(LATENCY) + 4; c++) begin
      @(negedge clk_i);
      if (c == 0) checkVal("stall_first", 32'(stall_o), 32'd1);
      if (valid_o) begin
        seen = 1;
        break;
      end
      if (stall_o) stalls++;
      @(posedge clk_i); #1;
    end
    checkVal("valid_seen", 32'(seen), 32'd1);
    checkVal("stall_count", 32'(stalls), 32'(LATENCY));
    checkVal("done_stall", 32'(stall_o), 32'd0);
    checkVal("mem_data", MemData_o, expData);
    @(posedge clk_i); #1;
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b0;
  endtask

  task automatic idleCycle();
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b0;
    @(negedge clk_i);
    checkVal("idle_stall", 32'(stall_o), 32'd0);
    checkVal("idle_valid", 32'(valid_o), 32'd0);
    checkVal("idle_data", MemData_o, expData);
    @(posedge clk_i); #1;
  endtask

  initial begin
    logic [31:0] a;
    int          op;
    int          idx;
    rst_i        = 1'b0;
    MemRead_i    = 1'b0;
    MemWrite_i   = 1'b0;
    ALUResult_i  = '0;
    MUX2Result_i = '0;
    expData      = '0;
    for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;

    // Reset, then idle with no requests.
    repeat (3) @(posedge clk_i);
    #1;
    @(negedge clk_i);
    checkVal("rst_stall", 32'(stall_o), 32'd0);
    checkVal("rst_valid", 32'(valid_o), 32'd0);
    checkVal("rst_data", MemData_o, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    repeat (5) idleCycle();

    // Store then load; store leaves MemData_o alone.
    access(0, 1, 32'h10, 32'hDEADBEEF);
    access(1, 0, 32'h10, 32'h0);
    access(0, 1, 32'h14, 32'h12345678);
    // Back-to-back loads.
    access(1, 0, 32'h10, 32'h0);
    access(1, 0, 32'h14, 32'h0);
    // Both strobes: write wins.
    access(1, 1, 32'h20, 32'hA5A5A5A5);
    access(1, 0, 32'h20, 32'h0);

    // Reset in the second WAIT cycle aborts the store.
    access(0, 1, 32'h30, 32'hCAFEF00D);
    MemWrite_i   = 1'b1;
    ALUResult_i  = 32'h30;
    MUX2Result_i = 32'h1;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rst_i      = 1'b0;
    MemWrite_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i   = 1'b1;
    expData = '0;
    @(negedge clk_i);
    checkVal("abort_stall", 32'(stall_o), 32'd0);
    checkVal("abort_valid", 32'(valid_o), 32'd0);
    checkVal("abort_data", MemData_o, 32'd0);
    @(posedge clk_i); #1;
    access(1, 0, 32'h30, 32'h0);
    // Address wraps modulo DEPTH words.
    access(1, 0, 32'(DEPTH * 4) + 32'h10, 32'h0);

`ifdef DMEM_MISALIGN_TRAP_EN
    // Misaligned load is rejected with a one-cycle error pulse.
    MemRead_i   = 1'b1;
    ALUResult_i = 32'h13;
    @(negedge clk_i);
    checkVal("mis_stall", 32'(stall_o), 32'd0);
    checkVal("mis_err_now", 32'(err_o), 32'd0);
    @(posedge clk_i); #1;
    MemRead_i = 1'b0;
    @(negedge clk_i);
    checkVal("mis_err", 32'(err_o), 32'd1);
    checkVal("mis_data", MemData_o, expData);
    checkVal("mis_state_valid", 32'(valid_o), 32'd0);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    checkVal("mis_err_clr", 32'(err_o), 32'd0);
    @(posedge clk_i); #1;
`else
    // Low address bits ignored: truncates to word 0x10.
    access(1, 0, 32'h13, 32'h0);
`endif

    // Randomized mix over a small window of words with random upper bits.
    for (int n = 0; n < 60; n++) begin
      op  = int'($urandom_range(0, 4));
      idx = int'($urandom_range(0, 15));
      a   = ($urandom & ~32'hFF) | (32'(idx) << 2);
`ifndef DMEM_MISALIGN_TRAP_EN
      a   = a | 32'($urandom_range(0, 3));
`endif
      case (op)
        0:       idleCycle();
        1, 2:    access(1, 0, a, 32'h0);
        3:       access(0, 1, a, $urandom);
        default: access(1, 1, a, $urandom);
      endcase
    end
    idleCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
